// File: rtl/go_arbiter_if.sv
// Handshake bundle between the go_arbiter, its requesters and the shared go/done unit.
// master: arbiter side; slave: requesters plus shared unit.
interface go_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             unit_go;
  logic             unit_done;
  logic             err;

  modport master (
    input  req,
    input  unit_done,
    output ack,
    output grant_id,
    output busy,
    output unit_go,
    output err
  );

  modport slave (
    output req,
    output unit_done,
    input  ack,
    input  grant_id,
    input  busy,
    input  unit_go,
    input  err
  );
endinterface

// File: rtl/go_arbiter.sv
// Round-robin arbiter sharing one go/done processing unit among N_REQ requesters.
// Optional WAIT-state timeout abort is built when TIMEOUT_EN is defined.
module go_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  go_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic [N_REQ-1:0] ack;
  logic             busy;
  logic             unit_go;
  logic             err;

  logic [ID_W-1:0]  winner_c;
  logic [ID_W-1:0]  idx_c;
  logic [ID_W-1:0]  next_ptr_c;

  // First pending requester at or after ptr; later loop passes have smaller offset and win.
  always_comb begin
    winner_c = ptr;
    idx_c    = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_c = ID_W'((32'(ptr) + N_REQ - 1 - i) % N_REQ);
      if (bus.req[idx_c]) begin
        winner_c = idx_c;
      end
    end
  end

  assign next_ptr_c = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout_c;

  assign timeout_c = (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic cfg_unused;

  assign cfg_unused = ^{32'(TIMEOUT), 32'(CNT_W)};
`endif

  // Single-process FSM; all outputs registered, pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      unit_go  <= 1'b0;
      err      <= 1'b0;
`ifdef TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      ack     <= '0;
      unit_go <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_id <= winner_c;
            unit_go  <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
`ifdef TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // A done coinciding with the timeout wins, so err stays low.
          if (bus.unit_done) begin
            ack   <= N_REQ'(1) << grant_id;
            state <= ACK;
`ifdef TIMEOUT_EN
          end else if (timeout_c) begin
            ack   <= N_REQ'(1) << grant_id;
            err   <= 1'b1;
            state <= ACK;
          end else begin
            cnt   <= cnt + 1'b1;
`endif
          end
        end
        ACK: begin
          busy  <= 1'b0;
          ptr   <= next_ptr_c;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = ack;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;
  assign bus.unit_go  = unit_go;
  assign bus.err      = err;

endmodule
